flash_cmd_sequencer: RTL and testbench



---
 rtl/flash_cmd_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_flash_cmd_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_sequencer.sv
// Host-side sequencer for the NAND flash model: one operation at a time
// (erase, program page, read page) driven over a shared 16-bit DIO bus
// with registered CLE/ALE/wEn/rEn/cEn strobes and a status handshake.
module flash_cmd_sequencer #(
    parameter int                PAGE_SIZE      = 2048,
    parameter int                ADDR_W         = 16,
    parameter logic [ADDR_W-1:0] CMD_ERASE      = 16'h0060,
    parameter logic [ADDR_W-1:0] CMD_PROGRAM    = 16'h0080,
    parameter logic [ADDR_W-1:0] CMD_READ       = 16'h0000,
    parameter int                STATUS_TIMEOUT = 4096,
    parameter int                INIT_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              opValid,
    output logic              opReady,
    input  logic [1:0]        opCode,
    input  logic [ADDR_W-1:0] opAddr,
    output logic              wrReq,
    input  logic [ADDR_W-1:0] wrData,
    output logic              rdValid,
    output logic [ADDR_W-1:0] rdData,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              cEn,
    output logic              CLE,
    output logic              ALE,
    output logic              wEn,
    output logic              rEn,
    input  logic              status,
    inout  wire  [ADDR_W-1:0] DIO
);

    localparam int BEAT_W  = $clog2(PAGE_SIZE);
    localparam int TIMER_W = $clog2(STATUS_TIMEOUT);
    localparam int INIT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(PAGE_SIZE - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STATUS_TIMEOUT - 1);
    localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_CYCLES - 1);

    localparam logic [1:0] OP_ERASE   = 2'b00;
    localparam logic [1:0] OP_PROGRAM = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_WAIT_STAT
    } state_t;

    state_t              state, state_next;
    logic [1:0]          op_code, op_code_next;
    logic [ADDR_W-1:0]   op_addr, op_addr_next;
    logic [BEAT_W-1:0]   beat, beat_next;
    logic [TIMER_W-1:0]  timer, timer_next;
    logic [INIT_W-1:0]   init_cnt, init_cnt_next;
    logic [ADDR_W-1:0]   dio_out, dio_out_next;
    logic                ready_next, busy_next, done_next, err_next;
    logic                cle_next, ale_next, wen_next, ren_next, wrreq_next;

    // Command/address words come from a register; program beats pass straight through
    assign DIO = (CLE || ALE) ? dio_out : (wEn ? wrData : {ADDR_W{1'bz}});

    // Next-state and next-strobe decode; every strobe defaults low each cycle
    always_comb begin
        state_next    = state;
        op_code_next  = op_code;
        op_addr_next  = op_addr;
        beat_next     = beat;
        timer_next    = '0;
        init_cnt_next = init_cnt;
        dio_out_next  = dio_out;
        ready_next    = 1'b0;
        busy_next     = busy;
        done_next     = 1'b0;
        err_next      = 1'b0;
        cle_next      = 1'b0;
        ale_next      = 1'b0;
        wen_next      = 1'b0;
        ren_next      = 1'b0;
        wrreq_next    = 1'b0;

        case (state)
            S_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_next = S_IDLE;
                    ready_next = 1'b1;
                end else begin
                    init_cnt_next = init_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                ready_next = 1'b1;
                if (opValid && opReady) begin
                    op_code_next = opCode;
                    op_addr_next = opAddr;
                    if (opCode == 2'b11) begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                        busy_next = 1'b0;
                    end else begin
                        state_next = S_CMD;
                        ready_next = 1'b0;
                        busy_next  = 1'b1;
                        cle_next   = 1'b1;
                        case (opCode)
                            OP_ERASE:   dio_out_next = CMD_ERASE;
                            OP_PROGRAM: dio_out_next = CMD_PROGRAM;
                            default:    dio_out_next = CMD_READ;
                        endcase
                    end
                end
            end
            S_CMD: begin
                state_next   = S_ADDR;
                ale_next     = 1'b1;
                dio_out_next = op_addr;
            end
            S_ADDR: begin
                beat_next = '0;
                case (op_code)
                    OP_PROGRAM: begin
                        state_next = S_WRITE;
                        wen_next   = 1'b1;
                        wrreq_next = 1'b1;
                    end
                    OP_READ: begin
                        state_next = S_READ;
                        ren_next   = 1'b1;
                    end
                    default: state_next = S_WAIT_STAT;
                endcase
            end
            S_WRITE: begin
                if (beat == BEAT_LAST) begin
                    state_next = S_WAIT_STAT;
                end else begin
                    beat_next  = beat + 1'b1;
                    wen_next   = 1'b1;
                    wrreq_next = 1'b1;
                end
            end
            S_READ: begin
                if (beat == BEAT_LAST) begin
                    state_next = S_WAIT_STAT;
                end else begin
                    beat_next = beat + 1'b1;
                    ren_next  = 1'b1;
                end
            end
            S_WAIT_STAT: begin
                if (status) begin
                    state_next = S_IDLE;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else if (timer == TIMER_LAST) begin
                    state_next = S_IDLE;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    // State, strobes and handshake outputs all come straight from flops
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= S_INIT;
            op_code  <= '0;
            op_addr  <= '0;
            beat     <= '0;
            timer    <= '0;
            init_cnt <= '0;
            dio_out  <= '0;
            opReady  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cEn      <= 1'b0;
            CLE      <= 1'b0;
            ALE      <= 1'b0;
            wEn      <= 1'b0;
            rEn      <= 1'b0;
            wrReq    <= 1'b0;
        end else begin
            state    <= state_next;
            op_code  <= op_code_next;
            op_addr  <= op_addr_next;
            beat     <= beat_next;
            timer    <= timer_next;
            init_cnt <= init_cnt_next;
            dio_out  <= dio_out_next;
            opReady  <= ready_next;
            busy     <= busy_next;
            done     <= done_next;
            err      <= err_next;
            cEn      <= 1'b1;
            CLE      <= cle_next;
            ALE      <= ale_next;
            wEn      <= wen_next;
            rEn      <= ren_next;
            wrReq    <= wrreq_next;
        end
    end

    // Capture the memory's read beat one cycle after each rEn cycle
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdValid <= 1'b0;
            rdData  <= '0;
        end else begin
            rdValid <= rEn;
            if (rEn) begin
                rdData <= DIO;
            end
        end
    end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: a small NAND memory stub on the bus, a
// cycle-relative reference model of the host-visible behaviour, a per-cycle
// compare process, and directed operations with hand-computed expectations.
module tb_flash_cmd_sequencer;

    localparam int P          = 2048;
    localparam int TO         = 4096;
    localparam int INIT_CYC   = 2;
    localparam int STAT_DELAY = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        opValid;
    logic        opReady;
    logic [1:0]  opCode;
    logic [15:0] opAddr;
    logic        wrReq;
    logic [15:0] wrData;
    logic        rdValid;
    logic [15:0] rdData;
    logic        done, err, busy, cEn, CLE, ALE, wEn, rEn;
    logic        status = 1'b0;
    wire  [15:0] DIO;

    int n_checks = 0;
    int n_fail   = 0;

    flash_cmd_sequencer dut (
        .clk     (clk),
        .rstN    (rstN),
        .opValid (opValid),
        .opReady (opReady),
        .opCode  (opCode),
        .opAddr  (opAddr),
        .wrReq   (wrReq),
        .wrData  (wrData),
        .rdValid (rdValid),
        .rdData  (rdData),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .cEn     (cEn),
        .CLE     (CLE),
        .ALE     (ALE),
        .wEn     (wEn),
        .rEn     (rEn),
        .status  (status),
        .DIO     (DIO)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory stub ----------------
    logic [15:0] store   [0:65535];
    bit          written [0:65535];
    logic [15:0] s_cmd  = 16'h0;
    logic [15:0] s_addr = 16'h0;
    logic [15:0] s_cnt  = 16'h0;
    logic        pend   = 1'b0;
    int          dly    = 0;
    bit          stat_en = 1'b1;
    logic [15:0] rd_ptr, rd_word;
    logic [15:0] wr_cnt = 16'h0;

    assign rd_ptr  = (s_addr & 16'hF800) + s_cnt;
    assign rd_word = written[rd_ptr] ? store[rd_ptr] : 16'hA5A5;
    assign DIO     = rEn ? rd_word : 16'hzzzz;
    assign wrData  = wr_cnt;

    // Memory stub: latches command/address, stores/returns page beats, raises status after idle
    always @(posedge clk) begin
        status <= 1'b0;
        if (CLE) s_cmd <= DIO;
        if (ALE) begin
            s_addr <= DIO;
            s_cnt  <= 16'h0;
            if (s_cmd == 16'h0060) begin
                for (int i = 0; i < 8192; i++) begin
                    store[int'(DIO & 16'hE000) + i]   <= 16'h0000;
                    written[int'(DIO & 16'hE000) + i] <= 1'b1;
                end
            end
        end
        if (wEn) begin
            store[rd_ptr]   <= DIO;
            written[rd_ptr] <= 1'b1;
            s_cnt           <= s_cnt + 16'd1;
        end
        if (rEn) s_cnt <= s_cnt + 16'd1;
        if (CLE || ALE || wEn || rEn) begin
            pend <= 1'b1;
            dly  <= STAT_DELAY;
        end else if (pend) begin
            if (dly == 0) begin
                status <= stat_en;
                pend   <= 1'b0;
            end else begin
                dly <= dly - 1;
            end
        end
    end

    // Host write-data source: beat index of the current program operation
    always @(posedge clk) begin
        if (opValid) wr_cnt <= 16'h0;
        else if (wrReq) wr_cnt <= wr_cnt + 16'd1;
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [0:65535];
    bit          ref_wr  [0:65535];
    int          cyc = 0, up = 0, rel = 0, wait_at = 0;
    bit          active = 1'b0, e_ready = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [1:0]  kind = 2'b00;
    logic [15:0] m_addr = 16'h0;

    function automatic logic [15:0] ref_val(input int a);
        return ref_wr[a] ? ref_mem[a] : 16'hA5A5;
    endfunction

    function automatic logic [15:0] cmd_of(input logic [1:0] k);
        case (k)
            2'b00:   return 16'h0060;
            2'b01:   return 16'h0080;
            default: return 16'h0000;
        endcase
    endfunction

    // Model: tracks cycles since accept and derives the expected outcome of each op
    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (!rstN) begin
            up = 0; active = 0; e_ready = 0; e_done = 0; e_err = 0; rel = 0;
        end else begin
            acc    = e_ready && opValid;
            e_done = 0;
            e_err  = 0;
            if (active) begin
                rel++;
                if (rel - 1 >= wait_at && status) begin
                    e_done = 1; active = 0;
                end else if (rel == wait_at + TO) begin
                    e_done = 1; e_err = 1; active = 0;
                end
            end else if (acc) begin
                if (opCode == 2'b11) begin
                    e_done = 1; e_err = 1;
                end else begin
                    active  = 1;
                    rel     = 1;
                    kind    = opCode;
                    m_addr  = opAddr;
                    wait_at = (opCode == 2'b00) ? 3 : 3 + P;
                    if (opCode == 2'b01)
                        for (int i = 0; i < P; i++) begin
                            ref_mem[int'(opAddr & 16'hF800) + i] = 16'(i);
                            ref_wr[int'(opAddr & 16'hF800) + i]  = 1'b1;
                        end
                    if (opCode == 2'b00)
                        for (int i = 0; i < 8192; i++) begin
                            ref_mem[int'(opAddr & 16'hE000) + i] = 16'h0000;
                            ref_wr[int'(opAddr & 16'hE000) + i]  = 1'b1;
                        end
                end
            end
            up++;
            e_ready = (up >= INIT_CYC) && !active;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [15:0] cap_cle = 16'h0, cap_ale = 16'h0, last_rd = 16'h0;
    int          rd_total = 0, done_total = 0, strobe_total = 0, done_cyc = 0;
    logic        done_err = 1'b0;

    // Compare DUT outputs against the model every cycle, and log observations
    always @(negedge clk) begin
        if (!rstN) begin
            check("rst_cEn", cEn, 0);       check("rst_opReady", opReady, 0);
            check("rst_busy", busy, 0);     check("rst_done", done, 0);
            check("rst_err", err, 0);       check("rst_CLE", CLE, 0);
            check("rst_ALE", ALE, 0);       check("rst_wEn", wEn, 0);
            check("rst_rEn", rEn, 0);       check("rst_wrReq", wrReq, 0);
            check("rst_rdValid", rdValid, 0); check("rst_rdData", rdData, 0);
        end else begin
            bit x_cle, x_ale, x_wen, x_ren, x_rdv;
            x_cle = active && rel == 1;
            x_ale = active && rel == 2;
            x_wen = active && kind == 2'b01 && rel >= 3 && rel <= 2 + P;
            x_ren = active && kind == 2'b10 && rel >= 3 && rel <= 2 + P;
            x_rdv = active && kind == 2'b10 && rel >= 4 && rel <= 3 + P;
            check("cEn", cEn, up >= 1);
            check("opReady", opReady, e_ready);
            check("busy", busy, active);
            check("done", done, e_done);
            check("err", err, e_err);
            check("CLE", CLE, x_cle);
            check("ALE", ALE, x_ale);
            check("wEn", wEn, x_wen);
            check("wrReq", wrReq, x_wen);
            check("rEn", rEn, x_ren);
            check("rdValid", rdValid, x_rdv);
            if (x_cle) check("cmd_word", DIO, cmd_of(kind));
            if (x_ale) check("addr_word", DIO, m_addr);
            if (x_wen) check("wr_dio", DIO, rel - 3);
            if (x_rdv) check("rd_data", rdData, ref_val(int'(m_addr & 16'hF800) + rel - 4));
        end
        if (CLE) cap_cle = DIO;
        if (ALE) cap_ale = DIO;
        if (rdValid) begin rd_total++; last_rd = rdData; end
        if (done) begin done_total++; done_cyc = cyc; done_err = err; end
        if (CLE || ALE || wEn || rEn) strobe_total++;
    end

    // ---------------- stimulus ----------------
    int acc_cyc = 0;

    task automatic issue(input logic [1:0] code, input logic [15:0] addr);
        int n = 0;
        @(posedge clk); #1;
        while (!e_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("accept_ready", opReady, 1'b1);
        opCode  = code;
        opAddr  = addr;
        opValid = 1'b1;
        acc_cyc = cyc;
        @(posedge clk); #1;
        opValid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
        end
        if (n >= budget) check("done_seen", done, 1'b1);
        #1;
    endtask

    initial begin
        int r0, d0, s0, n;
        rstN = 1'b0; opValid = 1'b0; opCode = 2'b00; opAddr = 16'h0;
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;
        @(posedge clk); #1;
        check("init_cEn", cEn, 1'b1);
        check("init_ready_low", opReady, 1'b0);
        @(posedge clk); #1;
        check("init_ready", opReady, 1'b1);

        // Erase, then confirm the block reads back as zeros
        issue(2'b00, 16'h2345);
        wait_done(200);
        check("erase_cmd", cap_cle, 16'h0060);
        check("erase_addr", cap_ale, 16'h2345);
        check("erase_err", done_err, 1'b0);
        check("erase_lat", done_cyc - acc_cyc, 8);

        r0 = rd_total;
        issue(2'b10, 16'h2000);
        wait_done(3000);
        check("read0_count", rd_total - r0, 2048);
        check("read0_last", last_rd, 16'h0000);
        check("read0_lat", done_cyc - acc_cyc, 2056);

        // Program beat-index pattern and read it back
        issue(2'b01, 16'h0800);
        wait_done(3000);
        check("prog_err", done_err, 1'b0);
        check("prog_lat", done_cyc - acc_cyc, 2056);

        r0 = rd_total;
        issue(2'b10, 16'h0800);
        wait_done(3000);
        check("read1_count", rd_total - r0, 2048);
        check("read1_last", last_rd, 16'h07FF);
        check("read1_err", done_err, 1'b0);

        // Status never arrives: timeout error
        stat_en = 1'b0;
        issue(2'b00, 16'h4000);
        wait_done(5000);
        check("timeout_err", done_err, 1'b1);
        check("timeout_lat", done_cyc - acc_cyc, 4099);
        check("timeout_ready", opReady, 1'b1);
        stat_en = 1'b1;

        // Illegal opcode: no bus activity, immediate error
        s0 = strobe_total;
        issue(2'b11, 16'h1234);
        wait_done(10);
        check("illegal_lat", done_cyc - acc_cyc, 1);
        check("illegal_err", done_err, 1'b1);
        check("illegal_strobes", strobe_total - s0, 0);

        // Reset in the middle of a program at beat 100
        issue(2'b01, 16'h0800);
        n = 0;
        while (!(active && rel == 103) && n < 500) begin @(negedge clk); n++; end
        check("pre_rst_wEn", wEn, 1'b1);
        d0 = done_total;
        #2 rstN = 1'b0;
        #1;
        check("rst_now_wEn", wEn, 1'b0);
        check("rst_now_busy", busy, 1'b0);
        check("rst_now_cEn", cEn, 1'b0);
        repeat (2) @(posedge clk);
        #2 rstN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_done", done_total - d0, 0);

        issue(2'b01, 16'h0800);
        wait_done(3000);
        check("reprog_err", done_err, 1'b0);
        check("reprog_lat", done_cyc - acc_cyc, 2056);

        r0 = rd_total;
        issue(2'b10, 16'h0800);
        wait_done(3000);
        check("read2_count", rd_total - r0, 2048);
        check("read2_last", last_rd, 16'h07FF);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
